// File: rtl/nco_clken_pkg.sv
// Shared constants, types and helpers for the NCO clock-enable generator.
// f_to_inc converts a frequency ratio into the phase-increment word for the default width.
package nco_clken_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int NUM_CH_MAX = 16;

  typedef logic [ACC_W_DEF-1:0] phase_t;

  // Rounded (f_out / f_ref) * 2^ACC_W_DEF; valid while f_out_hz < 2^31.
  function automatic phase_t f_to_inc(input longint unsigned f_ref_hz,
                                      input longint unsigned f_out_hz);
    longint unsigned num;
    num = (f_out_hz << ACC_W_DEF) + (f_ref_hz >> 1);
    return phase_t'(num / f_ref_hz);
  endfunction

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: increment/enable registers plus a phase accumulator.
// The accumulator carry becomes a one-cycle enable; its MSB is the square wave.
module nco_channel #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic [ACC_W-1:0] wr_phase,
  input  logic             wr_en,
  output logic             clken,
  output logic             clk_sq
);

  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] acc;
  logic             en;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum = {1'b0, acc} + {1'b0, inc};
  end

  // NOTE: state registers use non-blocking assignments so every channel samples
  // the pre-edge values of acc/inc regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      inc   <= '0;
      acc   <= '0;
      en    <= 1'b0;
      clken <= 1'b0;
    end else if (wr) begin
      inc   <= wr_inc;
      acc   <= wr_phase;
      en    <= wr_en;
      clken <= 1'b0;
    end else if (en) begin
      {clken, acc} <= sum;
    end else begin
      clken <= 1'b0;
    end
  end

  assign clk_sq = acc[ACC_W-1];

endmodule

// File: rtl/nco_clken_gen.sv
// Multi-channel numerically-controlled clock-enable generator.
// Top level decodes configuration writes and tracks a lock counter over all channels.
module nco_clken_gen
  import nco_clken_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int ACC_W       = ACC_W_DEF,
  parameter  int LOCK_CYCLES = 16,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] clken,
  output logic [NUM_CH-1:0] clk_sq,
  output logic              locked
);

  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);

  logic             accept;
  logic [LCK_W-1:0] lock_cnt;

  // Writes to channel numbers this build does not have are dropped completely.
  assign accept = cfg_we && (int'(cfg_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    assign wr = accept && (int'(cfg_ch) == i);

    nco_channel #(
      .ACC_W (ACC_W)
    ) u_channel (
      .clk      (refclk),
      .rst      (rst),
      .wr       (wr),
      .wr_inc   (cfg_inc),
      .wr_phase (cfg_phase),
      .wr_en    (cfg_en),
      .clken    (clken[i]),
      .clk_sq   (clk_sq[i])
    );
  end

  always_ff @(posedge refclk) begin
    if (rst || accept) begin
      lock_cnt <= '0;
    end else if (lock_cnt != LCK_W'(LOCK_CYCLES)) begin
      lock_cnt <= lock_cnt + LCK_W'(1);
    end
  end

  assign locked = (lock_cnt == LCK_W'(LOCK_CYCLES));

endmodule

// File: tb/tb_nco_clken_gen.sv
// Directed bench for nco_clken_gen: 4-channel main instance plus a 3-channel instance
// that shares the stimulus, used to observe writes aimed at a missing channel.
module tb_nco_clken_gen;
  import nco_clken_pkg::*;

  logic        refclk = 1'b0;
  logic        rst    = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_inc   = '0;
  logic [31:0] cfg_phase = '0;
  logic        cfg_en = 1'b0;
  logic [3:0]  clken;
  logic [3:0]  clk_sq;
  logic        locked;
  logic [2:0]  clken3;
  logic [2:0]  clk_sq3;
  logic        locked3;

  int vectors     = 0;
  int miscompares = 0;

  always #10 refclk = ~refclk;

  nco_clken_gen #(.NUM_CH(4), .ACC_W(32), .LOCK_CYCLES(16)) u_dut (
    .refclk (refclk), .rst (rst), .cfg_we (cfg_we), .cfg_ch (cfg_ch),
    .cfg_inc (cfg_inc), .cfg_phase (cfg_phase), .cfg_en (cfg_en),
    .clken (clken), .clk_sq (clk_sq), .locked (locked)
  );

  nco_clken_gen #(.NUM_CH(3), .ACC_W(32), .LOCK_CYCLES(16)) u_dut3 (
    .refclk (refclk), .rst (rst), .cfg_we (cfg_we), .cfg_ch (cfg_ch),
    .cfg_inc (cfg_inc), .cfg_phase (cfg_phase), .cfg_en (cfg_en),
    .clken (clken3), .clk_sq (clk_sq3), .locked (locked3)
  );

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [31:0] inc,
                           input logic [31:0] phase, input logic en);
    cfg_we    = 1'b1;
    cfg_ch    = ch;
    cfg_inc   = inc;
    cfg_phase = phase;
    cfg_en    = en;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (clken !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_clken got=%b exp=0000", clken);
    end
    vectors++;
    if (clk_sq !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_clk_sq got=%b exp=0000", clk_sq);
    end
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_locked got=%b exp=0", locked);
    end
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15 || k == 16) begin
        vectors++;
        if (locked !== (k == 16)) begin
          miscompares++;
          $display("FAIL reset_lock_rise k=%0d got=%b exp=%b", k, locked, k == 16);
        end
      end
    end
  endtask

  task automatic test_half_rate();
    cfg_write(2'd0, 32'h8000_0000, 32'h0000_0000, 1'b1);
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL half_lock_fall got=%b exp=0", locked);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k <= 8) begin
        vectors++;
        if (clken[0] !== (k % 2 == 0)) begin
          miscompares++;
          $display("FAIL half_clken k=%0d got=%b exp=%b", k, clken[0], k % 2 == 0);
        end
        vectors++;
        if (clk_sq[0] !== (k % 2 == 1)) begin
          miscompares++;
          $display("FAIL half_clk_sq k=%0d got=%b exp=%b", k, clk_sq[0], k % 2 == 1);
        end
      end
      if (k == 15 || k == 16) begin
        vectors++;
        if (locked !== (k == 16)) begin
          miscompares++;
          $display("FAIL half_lock_rise k=%0d got=%b exp=%b", k, locked, k == 16);
        end
      end
    end
  endtask

  task automatic test_phase_load();
    logic exp_sq;
    cfg_write(2'd2, 32'h4000_0000, 32'hC000_0000, 1'b1);
    vectors++;
    if (clk_sq[2] !== 1'b1 || clken[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL phase_cycle0 got sq=%b en=%b exp sq=1 en=0", clk_sq[2], clken[2]);
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_sq = (k % 4 == 3) || (k % 4 == 0);
      vectors++;
      if (clken[2] !== (k % 4 == 1) || clk_sq[2] !== exp_sq) begin
        miscompares++;
        $display("FAIL phase_seq k=%0d got en=%b sq=%b exp en=%b sq=%b",
                 k, clken[2], clk_sq[2], k % 4 == 1, exp_sq);
      end
    end
  endtask

  task automatic test_5mhz();
    phase_t inc;
    int pulses;
    int last;
    inc = f_to_inc(64'd50_000_000, 64'd5_000_000);
    vectors++;
    if (inc !== 32'h1999_999A) begin
      miscompares++;
      $display("FAIL f_to_inc got=%h exp=1999999a", inc);
    end
    cfg_write(2'd1, 32'h1999_999A, 32'h0000_0000, 1'b1);
    pulses = 0;
    last   = 0;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (clken[1]) begin
        vectors++;
        if (k - last !== 10) begin
          miscompares++;
          $display("FAIL five_mhz_spacing k=%0d got=%0d exp=10", k, k - last);
        end
        pulses++;
        last = k;
      end
    end
    vectors++;
    if (pulses !== 100) begin
      miscompares++;
      $display("FAIL five_mhz_count got=%0d exp=100", pulses);
    end
  endtask

  task automatic test_unused_channel();
    logic exp_sq;
    vectors++;
    if (locked3 !== 1'b1) begin
      miscompares++;
      $display("FAIL unused_pre_locked got=%b exp=1", locked3);
    end
    exp_sq = ~clk_sq3[0];
    cfg_write(2'd3, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (locked3 !== 1'b1 || clk_sq3[0] !== exp_sq) begin
        miscompares++;
        $display("FAIL unused_write k=%0d got lock=%b sq0=%b exp lock=1 sq0=%b",
                 k, locked3, clk_sq3[0], exp_sq);
      end
      exp_sq = ~exp_sq;
      tick();
    end
  endtask

  task automatic test_zero_inc();
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (clken[3] !== 1'b0 || clk_sq[3] !== 1'b1) begin
        miscompares++;
        $display("FAIL zero_inc k=%0d got en=%b sq=%b exp en=0 sq=1", k, clken[3], clk_sq[3]);
      end
      tick();
    end
  endtask

  task automatic test_disable();
    logic exp_sq0;
    cfg_write(2'd3, 32'h1000_0000, 32'h0000_0000, 1'b1);
    for (int k = 0; k < 20; k++) tick();
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL disable_pre_locked got=%b exp=1", locked);
    end
    exp_sq0 = ~clk_sq[0];
    cfg_write(2'd3, 32'h1000_0000, 32'h9000_0000, 1'b0);
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL disable_lock_fall got=%b exp=0", locked);
    end
    for (int k = 0; k <= 16; k++) begin
      vectors++;
      if (clken[3] !== 1'b0 || clk_sq[3] !== 1'b1 || clk_sq[0] !== exp_sq0) begin
        miscompares++;
        $display("FAIL disable_hold k=%0d got en3=%b sq3=%b sq0=%b exp en3=0 sq3=1 sq0=%b",
                 k, clken[3], clk_sq[3], clk_sq[0], exp_sq0);
      end
      if (k == 15 || k == 16) begin
        vectors++;
        if (locked !== (k == 16)) begin
          miscompares++;
          $display("FAIL disable_lock_rise k=%0d got=%b exp=%b", k, locked, k == 16);
        end
      end
      exp_sq0 = ~exp_sq0;
      tick();
    end
  endtask

  task automatic test_rst_with_write();
    rst = 1'b1;
    cfg_write(2'd0, 32'h4000_0000, 32'h8000_0000, 1'b1);
    rst = 1'b0;
    vectors++;
    if (clken !== 4'b0000 || clk_sq !== 4'b0000 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_write_clear got en=%b sq=%b lock=%b exp 0000 0000 0",
               clken, clk_sq, locked);
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k <= 5) begin
        vectors++;
        if (clken !== 4'b0000 || clk_sq !== 4'b0000) begin
          miscompares++;
          $display("FAIL rst_write_discard k=%0d got en=%b sq=%b exp 0000 0000",
                   k, clken, clk_sq);
        end
      end
      if (k == 15 || k == 16) begin
        vectors++;
        if (locked !== (k == 16)) begin
          miscompares++;
          $display("FAIL rst_write_lock k=%0d got=%b exp=%b", k, locked, k == 16);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_half_rate();
    test_phase_load();
    test_5mhz();
    test_unused_channel();
    test_zero_inc();
    test_disable();
    test_rst_with_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
